// File: rtl/rfphoenix_icfill_pkg.sv
// rfphoenix_icfill_pkg: shared types and constants for the I$ fill controller.
//   code_address_t  32-bit fetch/line address
//   ICACHE_*        cache geometry
//   fill_state_e    fill sequencer states
//   lowest_way()    priority pick of the lowest set bit in a 4-way mask
package rfphoenix_icfill_pkg;

  typedef logic [31:0] code_address_t;

  localparam int ICACHE_LINES = 128;
  localparam int ICACHE_WAYS  = 4;
  localparam int ICACHE_BEATS = 4;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_FILL,
    FS_TAGWR
  } fill_state_e;

  function automatic logic [1:0] lowest_way(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/rfphoenix_icfill_if.sv
// rfphoenix_icfill_if: memory line-read port of the I$ fill controller.
//   mem_req/mem_adr   line read request and 128-byte aligned address
//   mem_ack           request accepted
//   mem_dvld/mem_dat  returned data beat
//   mem_err           bus error during request or data return
// master = cache controller, slave = memory side.
interface rfphoenix_icfill_if
  import rfphoenix_icfill_pkg::*;
#(
  parameter int DBW = 256
);
  logic           mem_req;
  code_address_t  mem_adr;
  logic           mem_ack;
  logic           mem_dvld;
  logic [DBW-1:0] mem_dat;
  logic           mem_err;

  modport master (output mem_req, mem_adr,
                  input  mem_ack, mem_dvld, mem_dat, mem_err);
  modport slave  (input  mem_req, mem_adr,
                  output mem_ack, mem_dvld, mem_dat, mem_err);
endinterface

// File: rtl/rfphoenix_icplru.sv
// rfphoenix_icplru: per-line 3-bit tree-PLRU store for a 4-way cache.
//   rd_ndx/victim          victim decode for the line being looked up
//   upd/upd_ndx/upd_way    mark a way as most recently used
// Bit 0 selects the half, bit 1 ways 0/1, bit 2 ways 2/3. An access points
// the tree away from the accessed way. Used when RFPHOENIX_ICACHE_PLRU_EN
// is defined.
module rfphoenix_icplru #(
  parameter int LINES = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] rd_ndx,
  output logic [1:0] victim,
  input  logic       upd,
  input  logic [6:0] upd_ndx,
  input  logic [1:0] upd_way
);
  logic [2:0] plru [LINES];
  logic [2:0] rd_bits;

  always_comb begin
    rd_bits = plru[rd_ndx];
    victim  = rd_bits[0] ? (rd_bits[2] ? 2'd3 : 2'd2)
                         : (rd_bits[1] ? 2'd1 : 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) plru[i] <= '0;
    end else if (upd) begin
      case (upd_way)
        2'd0: begin plru[upd_ndx][0] <= 1'b1; plru[upd_ndx][1] <= 1'b1; end
        2'd1: begin plru[upd_ndx][0] <= 1'b1; plru[upd_ndx][1] <= 1'b0; end
        2'd2: begin plru[upd_ndx][0] <= 1'b0; plru[upd_ndx][2] <= 1'b1; end
        default: begin plru[upd_ndx][0] <= 1'b0; plru[upd_ndx][2] <= 1'b0; end
      endcase
    end
  end
endmodule

// File: rtl/rfphoenix_icfill.sv
// rfphoenix_icfill: 4-way I$ lookup and line-fill controller.
//   clk, rst           clock, asynchronous active-high reset
//   ip, ip_vld         fetch lookup request (ignored while busy)
//   hit/hit_way/miss   lookup result, one cycle after ip_vld
//   busy, fill_err     fill in progress / aborted-fill pulse
//   inv_all            invalidate every line
//   tag_ndx, tag_in    tag array read index and per-way read tags
//   tag_wr/ipo/way     tag array write at the end of a fill
//   mem                memory line-read port (rfphoenix_icfill_if.master)
//   dat_*              data array beat writes
// Build option: RFPHOENIX_ICACHE_PLRU_EN selects tree-PLRU replacement;
// otherwise a global round-robin counter picks the victim.
module rfphoenix_icfill
  import rfphoenix_icfill_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WAYS  = ICACHE_WAYS,
  parameter int BEATS = ICACHE_BEATS,
  parameter int DBW   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  code_address_t         ip,
  input  logic                  ip_vld,
  output logic                  hit,
  output logic [1:0]            hit_way,
  output logic                  miss,
  output logic                  busy,
  output logic                  fill_err,
  input  logic                  inv_all,
  output logic [6:0]            tag_ndx,
  input  logic [WAYS-1:0][24:0] tag_in,
  output logic                  tag_wr,
  output code_address_t         tag_ipo,
  output logic [1:0]            tag_way,
  rfphoenix_icfill_if.master    mem,
  output logic                  dat_wr,
  output logic [1:0]            dat_way,
  output logic [6:0]            dat_ndx,
  output logic [1:0]            dat_beat,
  output logic [DBW-1:0]        dat_o
);
  fill_state_e   state, state_nx;
  code_address_t ip_p1;
  logic          vld_p1;
  code_address_t miss_adr;
  logic [1:0]    victim_q, victim_nx, pol_victim;
  logic [1:0]    beat;
  logic          inv_pend;
  logic [WAYS-1:0] valid [LINES];
  logic [WAYS-1:0] match;
  logic [6:0]    lk_ndx, miss_ndx;
  logic          lk_take, leaving, inv_now;
  logic          unused_ip;

  assign lk_ndx    = ip_p1[13:7];
  assign miss_ndx  = miss_adr[13:7];
  assign unused_ip = ^ip_p1[6:0];
  assign busy      = (state != FS_IDLE);
  // The miss cycle itself is not busy yet, but a new lookup there would be lost.
  assign lk_take   = ip_vld & ~busy & ~miss;
  assign leaving   = (state != FS_IDLE) && (state_nx == FS_IDLE);
  // A pending invalidate is honoured on any return to IDLE, including aborts.
  assign inv_now   = (state == FS_IDLE && inv_all) || (leaving && (inv_pend || inv_all));

  // ---- lookup stage: compare registered fetch address with tag array output
  always_comb begin
    for (int w = 0; w < WAYS; w++)
      match[w] = valid[lk_ndx][w] && (tag_in[w] == ip_p1[31:7]);
    hit       = vld_p1 & (|match);
    miss      = vld_p1 & ~(|match);
    hit_way   = hit ? lowest_way(match) : 2'd0;
    victim_nx = (&valid[lk_ndx]) ? pol_victim : lowest_way(~valid[lk_ndx]);
  end

`ifdef RFPHOENIX_ICACHE_PLRU_EN
  rfphoenix_icplru #(.LINES(LINES)) u_plru (
    .clk     (clk),
    .rst     (rst),
    .rd_ndx  (lk_ndx),
    .victim  (pol_victim),
    .upd     (hit || (state == FS_TAGWR)),
    .upd_ndx ((state == FS_TAGWR) ? miss_ndx : lk_ndx),
    .upd_way ((state == FS_TAGWR) ? victim_q : hit_way)
  );
`else
  logic [1:0] rr_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    rr_cnt <= 2'd0;
    else if (state == FS_TAGWR) rr_cnt <= rr_cnt + 2'd1;
  end
  assign pol_victim = rr_cnt;
`endif

  // ---- fill sequencer
  always_comb begin
    state_nx     = state;
    tag_ndx      = miss_ndx;
    mem.mem_req  = 1'b0;
    mem.mem_adr  = '0;
    dat_wr       = 1'b0;
    dat_way      = 2'd0;
    dat_ndx      = 7'd0;
    dat_beat     = 2'd0;
    dat_o        = '0;
    tag_wr       = 1'b0;
    tag_ipo      = '0;
    tag_way      = 2'd0;
    fill_err     = 1'b0;
    case (state)
      FS_IDLE: begin
        tag_ndx = ip[13:7];
        if (miss) state_nx = FS_REQ;
      end
      FS_REQ: begin
        mem.mem_req = 1'b1;
        mem.mem_adr = miss_adr;
        if (mem.mem_err) begin
          fill_err = 1'b1;
          state_nx = FS_IDLE;
        end else if (mem.mem_ack) begin
          state_nx = FS_FILL;
        end
      end
      FS_FILL: begin
        if (mem.mem_err) begin
          fill_err = 1'b1;
          state_nx = FS_IDLE;
        end else if (mem.mem_dvld) begin
          dat_wr   = 1'b1;
          dat_way  = victim_q;
          dat_ndx  = miss_ndx;
          dat_beat = beat;
          dat_o    = mem.mem_dat;
          if (beat == 2'(BEATS - 1)) state_nx = FS_TAGWR;
        end
      end
      FS_TAGWR: begin
        tag_wr   = 1'b1;
        tag_ipo  = miss_adr;
        tag_way  = victim_q;
        state_nx = FS_IDLE;
      end
      default: state_nx = FS_IDLE;
    endcase
  end

  // ---- control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FS_IDLE;
      vld_p1   <= 1'b0;
      beat     <= 2'd0;
      inv_pend <= 1'b0;
      for (int i = 0; i < LINES; i++) valid[i] <= '0;
    end else begin
      state  <= state_nx;
      vld_p1 <= lk_take;
      if (state_nx != FS_FILL) beat <= 2'd0;
      else if (dat_wr)         beat <= beat + 2'd1;
      if (inv_now) begin
        for (int i = 0; i < LINES; i++) valid[i] <= '0;
      end else if (state == FS_TAGWR) begin
        valid[miss_ndx][victim_q] <= 1'b1;
      end
      if (state == FS_IDLE || leaving) inv_pend <= 1'b0;
      else if (inv_all)                inv_pend <= 1'b1;
    end
  end

  // ---- address/victim capture (data path, not reset)
  always_ff @(posedge clk) begin
    if (lk_take) ip_p1 <= ip;
    if (miss) begin
      miss_adr <= {ip_p1[31:7], 7'b0};
      victim_q <= victim_nx;
    end
  end
endmodule

// File: tb/tb_rfphoenix_icfill.sv
module tb_rfphoenix_icfill;
  import rfphoenix_icfill_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  code_address_t ip;
  logic          ip_vld;
  logic          hit, miss, busy, fill_err;
  logic [1:0]    hit_way;
  logic          inv_all;
  logic [6:0]    tag_ndx;
  logic [3:0][24:0] tag_in;
  logic          tag_wr;
  code_address_t tag_ipo;
  logic [1:0]    tag_way;
  logic          dat_wr;
  logic [1:0]    dat_way, dat_beat;
  logic [6:0]    dat_ndx;
  logic [255:0]  dat_o;

  int n_tests = 0;
  int n_fail  = 0;

  rfphoenix_icfill_if #(.DBW(256)) mbus ();

  rfphoenix_icfill #(.DBW(256)) dut (
    .clk(clk), .rst(rst), .ip(ip), .ip_vld(ip_vld),
    .hit(hit), .hit_way(hit_way), .miss(miss), .busy(busy), .fill_err(fill_err),
    .inv_all(inv_all), .tag_ndx(tag_ndx), .tag_in(tag_in),
    .tag_wr(tag_wr), .tag_ipo(tag_ipo), .tag_way(tag_way),
    .mem(mbus),
    .dat_wr(dat_wr), .dat_way(dat_way), .dat_ndx(dat_ndx),
    .dat_beat(dat_beat), .dat_o(dat_o)
  );

  always #5 clk = ~clk;

  // Tag array: synchronous read, write on tag_wr
  logic [24:0] tags [4][128];
  initial begin
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 128; i++) tags[w][i] = '0;
  end
  always @(posedge clk) begin
    if (tag_wr) tags[tag_way][tag_ipo[13:7]] <= tag_ipo[31:7];
    for (int w = 0; w < 4; w++) tag_in[w] <= tags[w][tag_ndx];
  end

`ifdef RFPHOENIX_ICACHE_PLRU_EN
  localparam logic [1:0] FULL_VICTIM = 2'd2;
`else
  localparam logic [1:0] FULL_VICTIM = 2'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ip_vld = 1'b0; inv_all = 1'b0;
    mbus.mem_ack = 1'b0; mbus.mem_dvld = 1'b0; mbus.mem_err = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Present a lookup in the current cycle; returns in the result cycle.
  task automatic lookup_now(input logic [31:0] a);
    ip = a; ip_vld = 1'b1;
    tick;
    ip_vld = 1'b0;
    #1;
  endtask

  task automatic lookup(input logic [31:0] a);
    tick;
    lookup_now(a);
  endtask

  // Called in the miss cycle. Ack arrives in the nreq-th request cycle.
  task automatic serve(input logic [31:0] adr, input logic [1:0] way, input int nreq,
                       input int err_beat, input int inv_beat);
    int n_req, n_wr;
    logic [31:0] word;
    n_req = 0; n_wr = 0;
    for (int k = 1; k <= nreq; k++) begin
      tick;
      mbus.mem_ack = (k == nreq);
      #1;
      if (k == 1) begin
        chk("req_adr", mbus.mem_adr, adr);
        chk("busy_req", 32'(busy), 32'd1);
      end
      if (mbus.mem_req) n_req++;
      if (dat_wr) n_wr++;
    end
    chk("req_cycles", n_req, nreq);
    chk("no_early_wr", n_wr, 0);
    for (int b = 0; b < 4; b++) begin
      tick;
      word = 32'hB0 + b;
      mbus.mem_ack = 1'b0; mbus.mem_dvld = 1'b1; mbus.mem_dat = {8{word}};
      mbus.mem_err = (b == err_beat);
      inv_all = (b == inv_beat);
      #1;
      if (b == err_beat) begin
        chk("err_pulse", 32'(fill_err), 32'd1);
        chk("err_nowr", 32'(dat_wr), 32'd0);
        tick;
        mbus.mem_dvld = 1'b0; mbus.mem_err = 1'b0;
        #1;
        chk("err_idle", 32'(busy), 32'd0);
        chk("err_notag", 32'(tag_wr), 32'd0);
        chk("err_pulse_end", 32'(fill_err), 32'd0);
        return;
      end
      chk("dat_wr", 32'(dat_wr), 32'd1);
      chk("dat_beat", 32'(dat_beat), b);
      chk("dat_way", 32'(dat_way), 32'(way));
      chk("dat_ndx", 32'(dat_ndx), 32'(adr[13:7]));
      chk("dat_o", dat_o[31:0], word);
    end
    tick;
    mbus.mem_dvld = 1'b0; inv_all = 1'b0;
    #1;
    chk("tag_wr", 32'(tag_wr), 32'd1);
    chk("tag_ipo", tag_ipo, adr);
    chk("tag_way", 32'(tag_way), 32'(way));
    tick;
    #1;
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    ip = '0; ip_vld = 1'b0; inv_all = 1'b0; rst = 1'b1;
    mbus.mem_ack = 1'b0; mbus.mem_dvld = 1'b0; mbus.mem_err = 1'b0; mbus.mem_dat = '0;
    tick; tick;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_hit_way", 32'(hit_way), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("rst_tag_wr", 32'(tag_wr), 32'd0);
    chk("rst_dat_wr", 32'(dat_wr), 32'd0);
    rst = 1'b0;

    // Basic miss, fill, re-lookup in the first IDLE cycle
    lookup(32'h0000_1000);
    chk("t1_miss", 32'(miss), 32'd1);
    chk("t1_nohit", 32'(hit), 32'd0);
    serve(32'h0000_1000, 2'd0, 1, -1, -1);
    lookup_now(32'h0000_1000);
    chk("t1_rehit", 32'(hit), 32'd1);
    chk("t1_rehit_way", 32'(hit_way), 32'd0);

    // Fill all four ways of index 0x20, then replacement
    lookup(32'h0000_5000); chk("t2_miss5", 32'(miss), 32'd1);
    serve(32'h0000_5000, 2'd1, 1, -1, -1);
    lookup(32'h0000_9000); chk("t2_miss9", 32'(miss), 32'd1);
    serve(32'h0000_9000, 2'd2, 1, -1, -1);
    lookup(32'h0000_D000); chk("t2_missD", 32'(miss), 32'd1);
    serve(32'h0000_D000, 2'd3, 1, -1, -1);
    lookup(32'h0000_5000);
    chk("t2_hit5", 32'(hit), 32'd1);
    chk("t2_hit5_way", 32'(hit_way), 32'd1);
    lookup(32'h0000_1000);
    chk("t2_hit1", 32'(hit), 32'd1);
    chk("t2_hit1_way", 32'(hit_way), 32'd0);
    lookup(32'h0001_1000);
    chk("t2_miss11", 32'(miss), 32'd1);
    serve(32'h0001_1000, FULL_VICTIM, 1, -1, -1);
    // Invalidate in IDLE
    inv_all = 1'b1;
    tick;
    inv_all = 1'b0;
    lookup(32'h0000_D000);
    chk("t2_inv_miss", 32'(miss), 32'd1);

    // Delayed ack
    do_reset;
    lookup(32'h0000_2000);
    chk("t3_miss", 32'(miss), 32'd1);
    serve(32'h0000_2000, 2'd0, 5, -1, -1);

    // Bus error on beat 2
    do_reset;
    lookup(32'h0000_1000);
    serve(32'h0000_1000, 2'd0, 1, 2, -1);
    lookup(32'h0000_1000);
    chk("t4_remiss", 32'(miss), 32'd1);

    // Invalidate during fill
    do_reset;
    lookup(32'h0000_1000);
    serve(32'h0000_1000, 2'd0, 1, -1, 1);
    lookup_now(32'h0000_1000);
    chk("t5_miss_after_inv", 32'(miss), 32'd1);

    // ip_vld while busy, reset mid-fill
    do_reset;
    lookup(32'h0000_3000);
    chk("t6_miss", 32'(miss), 32'd1);
    tick;
    ip = 32'h0000_4000; ip_vld = 1'b1;
    tick;
    ip_vld = 1'b0; mbus.mem_ack = 1'b1;
    #1;
    chk("t6_ign_hit", 32'(hit), 32'd0);
    chk("t6_ign_miss", 32'(miss), 32'd0);
    chk("t6_req", 32'(mbus.mem_req), 32'd1);
    tick;
    mbus.mem_ack = 1'b0; mbus.mem_dvld = 1'b1; mbus.mem_dat = '0;
    #1;
    chk("t6_beat0", 32'(dat_wr), 32'd1);
    tick;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(mbus.mem_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_wr", 32'(dat_wr), 32'd0);
    tick;
    rst = 1'b0; mbus.mem_dvld = 1'b0;
    lookup(32'h0000_3000);
    chk("t6_post_miss", 32'(miss), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rfphoenix_icfill.md
# rfphoenix_icfill

Instruction-cache lookup/fill controller wrapping the I$ tag array. Compares the four way tags against the fetch address, tracks per-line valid bits, chooses a victim way on a miss, sequences the line fetch from memory, writes line beats to the data array and finally writes the tag. It sits between the fetch stage, the tag/data arrays and the memory request port.

## Interface
- LINES, 128: sets per way (index = adr[13:7])
- WAYS, 4: associativity (fixed 4; tree-PLRU assumes 4)
- BEATS, 4: data beats per 128-byte line
- DBW, 256: beat width in bits
- clk  in  1  sole clock
- rst  in  1  reset; asynchronous, active-high
- ip  in  32 (code_address_t)  fetch address
- ip_vld  in  1  lookup request; ignored while busy
- hit  out  1  lookup hit, valid cycle after ip_vld
- hit_way  out  2  hitting way
- miss  out  1  lookup miss pulse, cycle after ip_vld
- busy  out  1  fill in progress
- fill_err  out  1  one-cycle pulse on aborted fill
- inv_all  in  1  invalidate all lines
- tag_ndx  out  7  tag array read index
- tag_in  in  4 x 25 ([31:7])  tag array read outputs
- tag_wr  out  1  tag write strobe
- tag_ipo  out  32  tag write address
- tag_way  out  2  tag write way
- mem_req  out  1  line read request
- mem_adr  out  32  line address, [6:0]=0
- mem_ack  in  1  request accepted
- mem_dvld  in  1  data beat valid
- mem_dat  in  DBW  data beat
- mem_err  in  1  bus error (sampled with or without mem_dvld during FILL)
- dat_wr  out  1  data array write strobe
- dat_way  out  2; dat_ndx  out  7; dat_beat  out  2; dat_o  out  DBW

## Operation
- Lookup: tag_ndx = ip[13:7] combinationally in IDLE, else miss index. ip_vld&~busy registers ip_q and lk_vld. Next cycle: way w matches if valid[w][ip_q[13:7]] & tag_in[w]==ip_q[31:7]; hit=lk_vld&any match, hit_way=lowest matching way, miss=lk_vld&~any.
- FSM: IDLE -> (miss) REQ -> (mem_ack) FILL -> (last beat) TAGWR -> IDLE.
- On miss: latch miss_adr={ip_q[31:7],7'b0}, victim; busy=1 from the next cycle until return to IDLE.
- REQ: mem_req=1, mem_adr=miss_adr; held until mem_ack sampled high.
- FILL: each mem_dvld: dat_wr=1, dat_way=victim, dat_ndx=miss_adr[13:7], dat_beat=beat counter, dat_o=mem_dat; counter increments, beat 3 -> TAGWR.
- mem_err in REQ/FILL: -> IDLE, fill_err pulse, no tag_wr, valid unchanged.
- TAGWR: tag_wr=1, tag_ipo=miss_adr, tag_way=victim, valid[victim][ndx] set, replacement state updated.
- Victim: lowest-numbered invalid way at the index; if all valid, replacement policy (see Configuration).
- inv_all in IDLE: all valid bits clear at that edge; hit in that cycle uses old valids. inv_all while busy: latched pending, applied on the TAGWR edge (the just-filled line ends invalid).
- Fetch unit re-presents ip after busy falls; the re-lookup hits.

## Timing
- Reset: all outputs 0, state IDLE, valid all 0, beat counter 0, replacement state 0, pending inv 0.
- Lookup latency 1 cycle; miss->mem_req 1 cycle; last beat->tag_wr 1 cycle; tag_wr->IDLE 1 cycle.
- The tag array write lands on the TAGWR edge; a lookup issued in the first IDLE cycle sees the new tag.
- Reset mid-fill: immediate abort, no partial tag write.

## Configuration
- RFPHOENIX_ICACHE_PLRU_EN defined: 3-bit tree-PLRU per line (b0 half, b1 ways 0/1, b2 ways 2/3). Victim = b0 ? (b2?3:2) : (b1?1:0). Access to w0 sets b0=1,b1=1; w1 b0=1,b1=0; w2 b0=0,b2=1; w3 b0=0,b2=0. Updated on hit and on TAGWR.
- Undefined: global 2-bit round-robin counter as victim, incremented on each TAGWR.

## Structure
- rfPhoenixPkg: code_address_t, ICACHE_LINES, ICACHE_WAYS, ICACHE_BEATS, fill-state enum.
- One sub-module: rfphoenix_icplru (per-line PLRU bit store, victim decode, update), instantiated only under the macro.

## Test plan
- Reset, lookup 0x0000_1000 -> miss; mem_adr=0x0000_1000; 4 dat_wr with beats 0..3, way 0; tag_wr ipo=0x1000 way 0; re-lookup -> hit, hit_way=0.
- Fill 0x1000, 0x5000, 0x9000, 0xD000 (all ndx 0x20) -> ways 0,1,2,3; hit 0x1000, then miss 0x11000 -> victim way 2 with PLRU, way 0 without.
- mem_ack delayed 5 cycles -> mem_req stays high 5 cycles, no dat_wr before ack.
- mem_err on beat 2 -> fill_err pulse, no tag_wr, re-lookup 0x1000 misses again.
- inv_all during FILL -> fill completes with tag_wr, then lookup 0x1000 -> miss.
- ip_vld while busy -> ignored; rst asserted mid-FILL -> mem_req=0, busy=0, next lookup misses.
